hazard_stall_unit: RTL and testbench
====================================

// Module: hazard_stall_unit
// PURPOSE
// - Stall/flush controller paired with the forwarding unit. It covers the hazards forwarding cannot resolve.
// - Load-use: inserts a 1-cycle bubble.
// - Taken branch resolved in EX: flushes the younger instructions in IF/ID and ID/EX.
// - Data-memory busy: freezes the whole pipeline. A watchdog enters a sticky error state if the wait exceeds a limit.
// PARAMETERS
// - TIMEOUT_CYCLES  16  consecutive mem_busy cycles before ERROR; legal range >= 2
// PORTS
// - clk               in   1  clock, rising edge
// - rst_n             in   1  reset, asynchronous, active-low
// - ID_EX_MemRead     in   1  instruction in EX is a load
// - ID_EX_rd          in   5  load destination
// - IF_ID_rs1         in   5  decode-stage source 1
// - IF_ID_rs2         in   5  decode-stage source 2
// - IF_ID_use_rs1     in   1  decode instruction reads rs1
// - IF_ID_use_rs2     in   1  decode instruction reads rs2
// - EX_branch_taken   in   1  branch/jump in EX redirects the PC this cycle
// - mem_busy          in   1  data memory not ready for the access in MEM
// - PC_write_en       out  1  PC update enable
// - IF_ID_write_en    out  1  IF/ID register enable
// - IF_ID_flush       out  1  IF/ID loads a NOP
// - ID_EX_write_en    out  1  ID/EX register enable
// - ID_EX_bubble      out  1  ID/EX loads a NOP (all control bits zero)
// - EX_MEM_write_en   out  1  EX/MEM register enable
// - MEM_WB_write_en   out  1  MEM/WB register enable
// - mem_timeout       out  1  sticky watchdog flag
// - stall_cycles      out  32 performance counter (see CONFIGURATION)
// - flush_count       out  32 performance counter (see CONFIGURATION)
// BEHAVIOUR
// - States: RUN, MEM_WAIT, ERROR. wait_cnt is $clog2(TIMEOUT_CYCLES) bits wide.
// - Reset (rst_n=0, takes effect immediately):
//   - state=RUN, wait_cnt=0, mem_timeout=0, counters=0.
//   - While rst_n is low, all *_write_en=0 and flush/bubble=0.
// - load_use = ID_EX_MemRead & (ID_EX_rd!=0) & ((IF_ID_use_rs1 & ID_EX_rd==IF_ID_rs1) | (IF_ID_use_rs2 & ID_EX_rd==IF_ID_rs2)).
// - Default outputs: all *_write_en=1, flush=0, bubble=0, mem_timeout as held.
// - Outputs are combinational from state and the current inputs; zero-cycle response.
// - RUN, priority order:
//   1. mem_busy: freeze. All 5 write enables=0; flush=0, bubble=0. wait_cnt<=1; next state MEM_WAIT.
//   2. else EX_branch_taken: IF_ID_flush=1, ID_EX_bubble=1; enables stay 1. A load_use in the same cycle is ignored, because its consumer is flushed.
//   3. else load_use: PC_write_en=0, IF_ID_write_en=0, ID_EX_bubble=1. Exactly 1 cycle; the load then reaches MEM and load_use clears.
// - MEM_WAIT:
//   - mem_busy=1: freeze as above.
//     - If wait_cnt==TIMEOUT_CYCLES-1: next state ERROR and mem_timeout<=1.
//     - Else wait_cnt++.
//   - mem_busy=0: evaluate exactly as RUN items 2-3 in this cycle; next state RUN; wait_cnt<=0.
// - ERROR: all write enables=0, flush=0, bubble=0, mem_timeout=1. Exit only via reset.
// - Branch or load-use arriving during a freeze is not acted on; the frozen stages re-present it on the first unfrozen cycle.
// - Writeback while frozen: MEM_WB is held, so WB rewrites the same value; this is idempotent and allowed.
// - Reset asserted mid-MEM_WAIT: immediate return to RUN, wait_cnt cleared, no timeout flagged.
// CONFIGURATION
// - Macro: HAZARD_PERF_CNT_EN.
// - Defined:
//   - stall_cycles increments on every load-use stall cycle and every freeze cycle, including ERROR cycles.
//   - flush_count increments on every cycle with IF_ID_flush=1.
//   - Both counters saturate at 32'hFFFFFFFF and reset to 0.
// - Undefined: no counter flops; stall_cycles and flush_count are tied to 32'd0. Ports remain in both builds.
// TESTING
// - Load-use: ID_EX_MemRead=1, ID_EX_rd=5, IF_ID_rs2=5, use_rs2=1 for 1 cycle -> PC_write_en=0, IF_ID_write_en=0, ID_EX_bubble=1 that cycle only.
// - No stall on x0: ID_EX_rd=0 with rs1=0, or use_rs1=0 with a matching rs1 -> all enables 1, bubble=0.
// - Branch + load-use in the same cycle -> IF_ID_flush=1, ID_EX_bubble=1, PC_write_en=1; flush_count +1 when HAZARD_PERF_CNT_EN.
// - mem_busy=1 for 3 cycles -> all enables 0 for exactly those 3 cycles, normal on the 4th; stall_cycles=3 when HAZARD_PERF_CNT_EN.
// - mem_busy held high, TIMEOUT_CYCLES=16 -> mem_timeout=1 from cycle 17; enables stay 0 after mem_busy drops until rst_n pulses low.
// - rst_n pulsed low at busy cycle 10 -> enables 0 during reset; after release with mem_busy=0: state RUN, enables 1, mem_timeout=0.

Source files
------------

// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - pipeline stall/flush controller with memory-wait watchdog
// Optional feature: define HAZARD_PERF_CNT_EN to build the stall/flush performance counters.
module hazard_stall_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ID_EX_MemRead,
  input  logic [4:0]  ID_EX_rd,
  input  logic [4:0]  IF_ID_rs1,
  input  logic [4:0]  IF_ID_rs2,
  input  logic        IF_ID_use_rs1,
  input  logic        IF_ID_use_rs2,
  input  logic        EX_branch_taken,
  input  logic        mem_busy,
  output logic        PC_write_en,
  output logic        IF_ID_write_en,
  output logic        IF_ID_flush,
  output logic        ID_EX_write_en,
  output logic        ID_EX_bubble,
  output logic        EX_MEM_write_en,
  output logic        MEM_WB_write_en,
  output logic        mem_timeout,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_ERROR    = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] wait_cnt, wait_next;
  logic          timeout_q, timeout_next;
  logic          load_use;

  // A load in EX whose destination is read by the decode-stage instruction (x0 never hazards)
  assign load_use = ID_EX_MemRead && (ID_EX_rd != 5'd0) &&
                    ((IF_ID_use_rs1 && (ID_EX_rd == IF_ID_rs1)) ||
                     (IF_ID_use_rs2 && (ID_EX_rd == IF_ID_rs2)));

  // State register with wait counter and sticky timeout flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_RUN;
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_next;
      wait_cnt  <= wait_next;
      timeout_q <= timeout_next;
    end
  end

  // Next-state logic: count consecutive busy cycles and trip the watchdog on the last one
  always_comb begin
    state_next   = state;
    wait_next    = wait_cnt;
    timeout_next = timeout_q;
    case (state)
      S_RUN: begin
        if (mem_busy) begin
          state_next = S_MEM_WAIT;
          wait_next  = CW'(1);
        end
      end
      S_MEM_WAIT: begin
        if (mem_busy) begin
          if (wait_cnt == WAIT_LAST) begin
            state_next   = S_ERROR;
            timeout_next = 1'b1;
          end else begin
            wait_next = wait_cnt + CW'(1);
          end
        end else begin
          state_next = S_RUN;
          wait_next  = '0;
        end
      end
      S_ERROR: begin
        state_next = S_ERROR;
      end
      default: begin
        state_next = S_RUN;
        wait_next  = '0;
      end
    endcase
  end

  // Output logic: freeze beats branch flush, which beats the load-use bubble
  always_comb begin
    PC_write_en     = 1'b1;
    IF_ID_write_en  = 1'b1;
    ID_EX_write_en  = 1'b1;
    EX_MEM_write_en = 1'b1;
    MEM_WB_write_en = 1'b1;
    IF_ID_flush     = 1'b0;
    ID_EX_bubble    = 1'b0;
    if (!rst_n || (state == S_ERROR) || mem_busy) begin
      PC_write_en     = 1'b0;
      IF_ID_write_en  = 1'b0;
      ID_EX_write_en  = 1'b0;
      EX_MEM_write_en = 1'b0;
      MEM_WB_write_en = 1'b0;
    end else if (EX_branch_taken) begin
      IF_ID_flush  = 1'b1;
      ID_EX_bubble = 1'b1;
    end else if (load_use) begin
      PC_write_en    = 1'b0;
      IF_ID_write_en = 1'b0;
      ID_EX_bubble   = 1'b1;
    end
  end

  assign mem_timeout = timeout_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_q, flush_q;

  // Saturating counters: PC is held exactly on load-use stalls and freezes, flush marks redirects
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!PC_write_en && (stall_q != 32'hFFFF_FFFF)) stall_q <= stall_q + 32'd1;
      if (IF_ID_flush && (flush_q != 32'hFFFF_FFFF)) flush_q <= flush_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`else
  assign stall_cycles = 32'd0;
  assign flush_count  = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb/tb_hazard_stall_unit.sv - randomized self-checking bench for hazard_stall_unit
module tb_hazard_stall_unit;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ID_EX_MemRead;
  logic [4:0]  ID_EX_rd, IF_ID_rs1, IF_ID_rs2;
  logic        IF_ID_use_rs1, IF_ID_use_rs2;
  logic        EX_branch_taken, mem_busy;
  logic        PC_write_en, IF_ID_write_en, IF_ID_flush, ID_EX_write_en;
  logic        ID_EX_bubble, EX_MEM_write_en, MEM_WB_write_en, mem_timeout;
  logic [31:0] stall_cycles, flush_count;

  int checks = 0;
  int errors = 0;

  // reference model: count of consecutive busy cycles, sticky error, counters
  int          m_busy_run = 0;
  bit          m_err = 0;
  logic [31:0] m_stall = 0;
  logic [31:0] m_flush = 0;

  always #5 clk = ~clk;

  hazard_stall_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_rd(ID_EX_rd),
    .IF_ID_rs1(IF_ID_rs1), .IF_ID_rs2(IF_ID_rs2),
    .IF_ID_use_rs1(IF_ID_use_rs1), .IF_ID_use_rs2(IF_ID_use_rs2),
    .EX_branch_taken(EX_branch_taken), .mem_busy(mem_busy),
    .PC_write_en(PC_write_en), .IF_ID_write_en(IF_ID_write_en),
    .IF_ID_flush(IF_ID_flush), .ID_EX_write_en(ID_EX_write_en),
    .ID_EX_bubble(ID_EX_bubble), .EX_MEM_write_en(EX_MEM_write_en),
    .MEM_WB_write_en(MEM_WB_write_en), .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Called just after a negedge with inputs applied; checks this cycle, advances the model
  task automatic run_cycle();
    bit lu, freeze, flush, stall;
    logic [4:0] en;
    #1;
    lu = ID_EX_MemRead && (ID_EX_rd != 0) &&
         ((IF_ID_use_rs1 && ID_EX_rd == IF_ID_rs1) || (IF_ID_use_rs2 && ID_EX_rd == IF_ID_rs2));
    freeze = rst_n && (m_err || mem_busy);
    flush  = rst_n && !freeze && EX_branch_taken;
    stall  = rst_n && !freeze && !EX_branch_taken && lu;
    if (!rst_n || freeze) en = 5'b00000;
    else if (stall)       en = 5'b11100;
    else                  en = 5'b11111;
    check("pc_we",    PC_write_en,     en[0]);
    check("ifid_we",  IF_ID_write_en,  en[1]);
    check("idex_we",  ID_EX_write_en,  en[2]);
    check("exmem_we", EX_MEM_write_en, en[3]);
    check("memwb_we", MEM_WB_write_en, en[4]);
    check("flush",    IF_ID_flush,     flush);
    check("bubble",   ID_EX_bubble,    flush || stall);
    check("timeout",  mem_timeout,     rst_n && m_err);
`ifdef HAZARD_PERF_CNT_EN
    check("stall_cnt", stall_cycles, rst_n ? m_stall : 32'd0);
    check("flush_cnt", flush_count,  rst_n ? m_flush : 32'd0);
`else
    check("stall_cnt", stall_cycles, 32'd0);
    check("flush_cnt", flush_count,  32'd0);
`endif
    if (!rst_n) begin
      m_busy_run = 0;
      m_err      = 0;
      m_stall    = 0;
      m_flush    = 0;
    end else begin
      if (!m_err) begin
        if (mem_busy) begin
          m_busy_run++;
          if (m_busy_run == TO) m_err = 1;
        end else begin
          m_busy_run = 0;
        end
      end
      if ((freeze || stall) && m_stall != 32'hFFFF_FFFF) m_stall++;
      if (flush && m_flush != 32'hFFFF_FFFF) m_flush++;
    end
    @(negedge clk);
  endtask

  task automatic drive(input bit rn, input bit mr, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input bit u1, input bit u2, input bit br, input bit busy);
    rst_n = rn; ID_EX_MemRead = mr; ID_EX_rd = rd; IF_ID_rs1 = rs1; IF_ID_rs2 = rs2;
    IF_ID_use_rs1 = u1; IF_ID_use_rs2 = u2; EX_branch_taken = br; mem_busy = busy;
    run_cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int busy_left;
    int err_age;
    rst_n = 0; ID_EX_MemRead = 0; ID_EX_rd = 0; IF_ID_rs1 = 0; IF_ID_rs2 = 0;
    IF_ID_use_rs1 = 0; IF_ID_use_rs2 = 0; EX_branch_taken = 0; mem_busy = 0;
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 5, 5, 5, 1, 1, 1, 1);
    idle(2);
    // load-use on rs2, one cycle only
    drive(1, 1, 5, 0, 5, 0, 1, 0, 0);
    idle(1);
    // x0 destination and unused-source matches must not stall
    drive(1, 1, 0, 0, 0, 1, 1, 0, 0);
    drive(1, 1, 7, 7, 3, 0, 1, 0, 0);
    // branch and load-use together: flush wins
    drive(1, 1, 5, 5, 0, 1, 0, 1, 0);
    idle(1);
    // short memory wait
    for (int i = 0; i < 3; i++) drive(1, 1, 5, 5, 0, 1, 0, 1, 1);
    idle(2);
    // watchdog trip, stays frozen after busy drops, cleared by reset
    for (int i = 0; i < 20; i++) drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    // reset in the middle of a wait, then a full wait of TO-1 cycles must not trip
    for (int i = 0; i < 10; i++) drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(2);
    for (int i = 0; i < TO - 1; i++) drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(2);

    busy_left = 0;
    err_age = 0;
    for (int n = 0; n < 3000; n++) begin
      bit rn, busy;
      if (busy_left == 0 && $urandom_range(0, 7) == 0) busy_left = $urandom_range(1, 20);
      busy = (busy_left != 0);
      if (busy_left != 0) busy_left--;
      err_age = m_err ? err_age + 1 : 0;
      rn = !(($urandom_range(0, 299) == 0) || err_age > 4);
      drive(rn, 1'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 5) == 0), busy);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
